// File: rtl/axi_mst_pkg.sv
// Shared types and AXI encodings for the burst master: FSM state, burst type and response codes.
package axi_mst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Response codes grow with severity, so the worst response is the numeric maximum.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI4 master-side bus bundle (AW/W/B/AR/R) for axi_burst_master.
// Every channel transfers on a clock edge where valid && ready; valid never waits on ready.
interface axi_burst_master_if
    import axi_mst_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   m_axi_awid;
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [7:0]            m_axi_awlen;
    logic [2:0]            m_axi_awsize;
    logic [1:0]            m_axi_awburst;
    logic                  m_axi_awlock;
    logic [3:0]            m_axi_awcache;
    logic [2:0]            m_axi_awprot;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;

    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_WIDTH-1:0] m_axi_wstrb;
    logic                  m_axi_wlast;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;

    logic [ID_WIDTH-1:0]   m_axi_bid;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;

    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );

endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master bridging a command port and write/read data streams.
// Optional error counter output enabled by defining AXI_BURST_MASTER_ERR_CNT_EN.
module axi_burst_master
    import axi_mst_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  done,
    output logic [1:0]            resp,
    output logic                  busy,
    output state_t                state_dbg,
`ifdef AXI_BURST_MASTER_ERR_CNT_EN
    output logic [15:0]           err_count,
`endif
    axi_burst_master_if.master    m_axi
);
    localparam int SIZE_LOG2 = $clog2(STRB_WIDTH);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            beat_cnt;
    logic [1:0]            rresp_max_q;
    logic                  cmd_hs, w_hs, r_hs;
    logic                  done_set;
    logic [1:0]            resp_set;
    logic                  unused_ids;

    assign unused_ids = ^{m_axi.m_axi_bid, m_axi.m_axi_rid};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            id_q        <= '0;
            beat_cnt    <= '0;
            rresp_max_q <= AXI_RESP_OKAY;
            done        <= 1'b0;
            resp        <= AXI_RESP_OKAY;
        end else begin
            state <= state_nxt;
            done  <= done_set;
            if (done_set) resp <= resp_set;
            if (cmd_hs) begin
                // Address is forced onto a full-bus-width boundary to match AxSIZE.
                addr_q      <= cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
                len_q       <= cmd_len;
                id_q        <= cmd_id;
                beat_cnt    <= '0;
                rresp_max_q <= AXI_RESP_OKAY;
            end
            if (w_hs) beat_cnt <= beat_cnt + 8'd1;
            if (r_hs) rresp_max_q <= resp_max(rresp_max_q, m_axi.m_axi_rresp);
        end
    end

`ifdef AXI_BURST_MASTER_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (done_set && resp_set != AXI_RESP_OKAY && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

    always_comb begin
        state_nxt            = state;
        cmd_ready            = 1'b0;
        cmd_hs               = 1'b0;
        w_hs                 = 1'b0;
        r_hs                 = 1'b0;
        done_set             = 1'b0;
        resp_set             = AXI_RESP_OKAY;
        wr_ready             = 1'b0;
        rd_valid             = 1'b0;
        rd_last              = 1'b0;
        m_axi.m_axi_awvalid  = 1'b0;
        m_axi.m_axi_wvalid   = 1'b0;
        m_axi.m_axi_wlast    = 1'b0;
        m_axi.m_axi_bready   = 1'b0;
        m_axi.m_axi_arvalid  = 1'b0;
        m_axi.m_axi_rready   = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = !rst;
                cmd_hs    = cmd_valid && !rst;
                if (cmd_hs) state_nxt = cmd_write ? ST_AW : ST_AR;
            end
            ST_AW: begin
                m_axi.m_axi_awvalid = 1'b1;
                if (m_axi.m_axi_awready) state_nxt = ST_W;
            end
            ST_W: begin
                m_axi.m_axi_wvalid = wr_valid;
                m_axi.m_axi_wlast  = (beat_cnt == len_q);
                wr_ready           = m_axi.m_axi_wready;
                w_hs               = wr_valid && m_axi.m_axi_wready;
                if (w_hs && m_axi.m_axi_wlast) state_nxt = ST_B;
            end
            ST_B: begin
                m_axi.m_axi_bready = 1'b1;
                if (m_axi.m_axi_bvalid) begin
                    state_nxt = ST_IDLE;
                    done_set  = 1'b1;
                    resp_set  = m_axi.m_axi_bresp;
                end
            end
            ST_AR: begin
                m_axi.m_axi_arvalid = 1'b1;
                if (m_axi.m_axi_arready) state_nxt = ST_R;
            end
            ST_R: begin
                rd_valid           = m_axi.m_axi_rvalid;
                rd_last            = m_axi.m_axi_rlast;
                m_axi.m_axi_rready = rd_ready;
                r_hs               = m_axi.m_axi_rvalid && rd_ready;
                if (r_hs && m_axi.m_axi_rlast) begin
                    state_nxt = ST_IDLE;
                    done_set  = 1'b1;
                    resp_set  = resp_max(rresp_max_q, m_axi.m_axi_rresp);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign m_axi.m_axi_awid    = id_q;
    assign m_axi.m_axi_awaddr  = addr_q;
    assign m_axi.m_axi_awlen   = len_q;
    assign m_axi.m_axi_awsize  = 3'(SIZE_LOG2);
    assign m_axi.m_axi_awburst = AXI_BURST_INCR;
    assign m_axi.m_axi_awlock  = 1'b0;
    assign m_axi.m_axi_awcache = 4'd0;
    assign m_axi.m_axi_awprot  = 3'd0;
    assign m_axi.m_axi_wdata   = wr_data;
    assign m_axi.m_axi_wstrb   = wr_strb;
    assign m_axi.m_axi_arid    = id_q;
    assign m_axi.m_axi_araddr  = addr_q;
    assign m_axi.m_axi_arlen   = len_q;
    assign m_axi.m_axi_arsize  = 3'(SIZE_LOG2);
    assign m_axi.m_axi_arburst = AXI_BURST_INCR;
    assign m_axi.m_axi_arlock  = 1'b0;
    assign m_axi.m_axi_arcache = 4'd0;
    assign m_axi.m_axi_arprot  = 3'd0;
    assign rd_data             = m_axi.m_axi_rdata;
    assign busy                = (state != ST_IDLE);
    assign state_dbg           = state;

endmodule
